// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory
//
// Collects a little-endian byte stream into 32-bit words and writes them to
// consecutive word addresses from BASE_ADDR. The core is held in reset
// (cpu_hold) until a load completes without error.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a 4-byte little-endian trailer follows the last data word
//   and must equal the mod-2^32 sum of all written words.
//
// Parameters:
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   DEPTH_WORDS  memory capacity in words; longer loads are rejected
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle load request (honoured only in IDLE/DONE)
//   num_words    program length in words, sampled with start
//   in_valid/in_data/in_ready  byte stream handshake, LSB of each word first
//   we/waddr/wdata             instruction memory write port
//   busy, done, error          load status
//   cpu_hold                   core reset request

module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] word_cnt;
  logic [15:0] word_total;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum;
  logic [23:0] trailer;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      we         <= 1'b0;
      waddr      <= BASE_ADDR;
      wdata      <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      byte_cnt   <= 2'd0;
      word_cnt   <= 16'd0;
      word_total <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 32'h0;
      trailer    <= 24'h0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (32'(num_words) > DEPTH_WORDS) begin
              state    <= S_DONE;
              done     <= 1'b1;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else if (num_words == 16'd0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              error    <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              // A reload holds the core again until the new image is complete.
              state      <= S_RECV;
              done       <= 1'b0;
              error      <= 1'b0;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
              in_ready   <= 1'b1;
              byte_cnt   <= 2'd0;
              word_cnt   <= 16'd0;
              word_total <= num_words;
              waddr      <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum       <= 32'h0;
`endif
            end
          end
        end

        // in_ready is registered high for the whole of RECV, so in_valid
        // alone marks an accepted byte here.
        S_RECV: begin
          if (in_valid) begin
            wdata[{byte_cnt, 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= S_WRITE;
              in_ready <= 1'b0;
              we       <= 1'b1;
            end
          end
        end

        // we is high for this single cycle; waddr/wdata are already stable.
        S_WRITE: begin
          we       <= 1'b0;
          waddr    <= waddr + 32'd4;
          word_cnt <= word_cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum     <= csum + wdata;
`endif
          if (word_cnt + 16'd1 == word_total) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= S_CHECK;
            in_ready <= 1'b1;
`else
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b0;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state    <= S_RECV;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // byte_cnt has wrapped back to 0 after the last data word.
        S_CHECK: begin
          if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              error    <= ({in_data, trailer} != csum);
              cpu_hold <= ({in_data, trailer} != csum);
            end else begin
              trailer[{byte_cnt, 3'b000} +: 8] <= in_data;
            end
          end
        end
`endif

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
